approx_add_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit approximate adders in the adder library.
- Adds two unsigned WIDTH-bit operands and produces a WIDTH+1-bit sum over STAGES registered carry-chain segments, with valid/ready handshakes on both sides.
- A per-transaction mode bit selects either an exact sum or a lower-part-OR approximation of the APPROX_BITS LSBs.
- Sits between operand producers and error/power characterisation harnesses, or datapath consumers, in the approximate-arithmetic test fabric.

---
 rtl/approx_add_pkg.sv | 40 ++++
 rtl/approx_add_seg.sv | 46 ++++
 rtl/approx_add_pipe.sv | 157 +++++++++++++++
 tb/tb_approx_add_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_add_pkg
// Description : Shared definitions for the pipelined approximate adder.
//               params_legal() - elaboration-time parameter legality check.
//               loa_sum()      - lower-part-OR golden function (result is
//                                width+1 bits, zero-extended to 65 bits).
// Revision    : 1.0 - initial release
// ============================================================================
package approx_add_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic bit params_legal(input int width, input int stages,
                                        input int approx_bits);
        if (width < 4 || width > MAX_WIDTH) return 1'b0;
        if (stages < 1 || (width % stages) != 0) return 1'b0;
        if (approx_bits < 0 || approx_bits >= (width / stages)) return 1'b0;
        return 1'b1;
    endfunction

    // Low k bits are a|b, the carry into bit k is a[k-1]&b[k-1], and the
    // remaining bits are an exact add of the upper operand parts.
    function automatic logic [MAX_WIDTH:0] loa_sum(input logic [MAX_WIDTH-1:0] a,
                                                  input logic [MAX_WIDTH-1:0] b,
                                                  input int k, input int width);
        logic [MAX_WIDTH:0] mask;
        logic [MAX_WIDTH:0] lo;
        logic [MAX_WIDTH:0] hi;
        logic               c;
        mask = (65'(1) << width) - 65'(1);
        lo   = {1'b0, (a | b)} & ((65'(1) << k) - 65'(1)) & mask;
        c    = 1'b0;
        if (k > 0) c = a[k-1] & b[k-1];
        hi   = (({1'b0, a} & mask) >> k) + (({1'b0, b} & mask) >> k) + 65'(c);
        return ((hi << k) | lo) & ((65'(1) << (width + 1)) - 65'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_add_seg.sv
`default_nettype none
// ============================================================================
// Module      : approx_add_seg
// Description : One SEG_W-bit ripple segment with carry-in/carry-out and an
//               optional lower-part-OR region of APPROX LSBs.
// Ports       : a, b      - segment operand slices
//               cin       - carry into the segment
//               approx_en - 1 selects the approximate result
//               s, cout   - segment sum and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module approx_add_seg #(
    parameter int SEG_W  = 8,
    parameter int APPROX = 0
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    localparam int              TOP_POS  = (APPROX > 0) ? APPROX - 1 : 0;
    localparam logic [SEG_W-1:0] LO_MASK  = SEG_W'((65'(1) << APPROX) - 65'(1));
    localparam logic [SEG_W-1:0] TOP_MASK = (APPROX > 0) ? SEG_W'(65'(1) << TOP_POS)
                                                         : '0;

    logic [SEG_W:0] w_exact;
    logic [SEG_W:0] w_approx;
    logic           w_kcarry;

    always_comb begin
        w_exact  = {1'b0, a} + {1'b0, b} + (SEG_W+1)'(cin);
        // The approximate region only exists in the first segment, where the
        // incoming carry is always zero, so cin is replaced by a[K-1]&b[K-1].
        // With no region the approximate path collapses to the exact add.
        w_kcarry = (APPROX > 0) ? |(a & b & TOP_MASK) : cin;
        w_approx = ({1'b0, a & ~LO_MASK} + {1'b0, b & ~LO_MASK}
                    + ((SEG_W+1)'(w_kcarry) << APPROX))
                   | {1'b0, (a | b) & LO_MASK};
        {cout, s} = approx_en ? w_approx : w_exact;
    end

endmodule
`default_nettype wire

// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_add_pipe
// Description : Pipelined WIDTH-bit adder, STAGES carry-chain segments, with a
//               per-beat exact / lower-part-OR approximate mode.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               in_valid/in_ready        - input handshake
//               a, b, approx_en          - operands and mode tag
//               out_valid/out_ready      - output handshake
//               sum (WIDTH+1), sum_approx - result and its mode tag
// Revision    : 1.0 - initial release
// ============================================================================
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 2,
    parameter int APPROX_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             sum_approx
);

    localparam int SEG = WIDTH / STAGES;

    if (!params_legal(WIDTH, STAGES, APPROX_BITS)) begin : g_param_check
        $error("approx_add_pipe: illegal WIDTH/STAGES/APPROX_BITS combination");
    end

    // Per-stage registers. a_q/b_q carry the full operands; each stage only
    // consumes its own slice. psum_q holds the sum bits produced so far.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] mode_q,  mode_d;
    logic [WIDTH-1:0]  a_q    [STAGES];
    logic [WIDTH-1:0]  a_d    [STAGES];
    logic [WIDTH-1:0]  b_q    [STAGES];
    logic [WIDTH-1:0]  b_d    [STAGES];
    logic [WIDTH-1:0]  psum_q [STAGES];
    logic [WIDTH-1:0]  psum_d [STAGES];

    // Stage inputs, selected from the ports or the previous stage.
    logic [WIDTH-1:0]  w_a_in    [STAGES];
    logic [WIDTH-1:0]  w_b_in    [STAGES];
    logic [WIDTH-1:0]  w_psum_in [STAGES];
    logic [SEG-1:0]    w_seg_a   [STAGES];
    logic [SEG-1:0]    w_seg_b   [STAGES];
    logic [SEG-1:0]    w_seg_sum [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_mode_in;
    logic [STAGES-1:0] w_valid_in;
    logic [STAGES-1:0] w_seg_cout;
    logic [STAGES-1:0] w_load;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_a_in[s]     = a;
            assign w_b_in[s]     = b;
            assign w_psum_in[s]  = '0;
            assign w_cin[s]      = 1'b0;
            assign w_mode_in[s]  = approx_en;
            assign w_valid_in[s] = in_valid;
        end else begin : g_next
            assign w_a_in[s]     = a_q[s-1];
            assign w_b_in[s]     = b_q[s-1];
            assign w_psum_in[s]  = psum_q[s-1];
            assign w_cin[s]      = carry_q[s-1];
            assign w_mode_in[s]  = mode_q[s-1];
            assign w_valid_in[s] = valid_q[s-1];
        end

        assign w_seg_a[s] = SEG'(w_a_in[s] >> (s * SEG));
        assign w_seg_b[s] = SEG'(w_b_in[s] >> (s * SEG));

        approx_add_seg #(
            .SEG_W  (SEG),
            .APPROX ((s == 0) ? APPROX_BITS : 0)
        ) u_seg (
            .a         (w_seg_a[s]),
            .b         (w_seg_b[s]),
            .cin       (w_cin[s]),
            .approx_en (w_mode_in[s]),
            .s         (w_seg_sum[s]),
            .cout      (w_seg_cout[s])
        );
    end

    always_comb begin
        // A stage may load when any slot from it to the output is empty, or
        // the consumer is taking the result: the whole chain then shifts.
        // Written in closed form so there is no bit-to-bit feedback in w_load.
        w_load = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_load[s] = out_ready;
            for (int j = s; j < STAGES; j++) begin
                if (!valid_q[j]) w_load[s] = 1'b1;
            end
        end

        valid_d = valid_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        for (int s = 0; s < STAGES; s++) begin
            a_d[s]    = a_q[s];
            b_d[s]    = b_q[s];
            psum_d[s] = psum_q[s];
            if (w_load[s]) begin
                valid_d[s] = w_valid_in[s];
                if (w_valid_in[s]) begin
                    a_d[s]     = w_a_in[s];
                    b_d[s]     = w_b_in[s];
                    mode_d[s]  = w_mode_in[s];
                    carry_d[s] = w_seg_cout[s];
                    psum_d[s]  = w_psum_in[s] | (WIDTH'(w_seg_sum[s]) << (s * SEG));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            mode_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]    <= '0;
                b_q[s]    <= '0;
                psum_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]    <= a_d[s];
                b_q[s]    <= b_d[s];
                psum_q[s] <= psum_d[s];
            end
        end
    end

    assign in_ready   = w_load[0];
    assign out_valid  = valid_q[STAGES-1];
    assign sum        = {carry_q[STAGES-1], psum_q[STAGES-1]};
    assign sum_approx = mode_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_add_pipe
// Description : Scoreboard bench for approx_add_pipe. Drivers push expected
//               results on input acceptance; monitors pop on output transfer.
//               dut0: 16/2/3, dut2: 32/4/0, dut3: 8/1/7.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_add_pipe;
    import approx_add_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid0, in_ready0, approx_en0, out_valid0, out_ready0, sum_approx0;
    logic [15:0] a0, b0;
    logic [16:0] sum0;
    logic        in_valid2, in_ready2, approx_en2, out_valid2, out_ready2, sum_approx2;
    logic [31:0] a2, b2;
    logic [32:0] sum2;
    logic        in_valid3, in_ready3, approx_en3, out_valid3, out_ready3, sum_approx3;
    logic [7:0]  a3, b3;
    logic [8:0]  sum3;

    approx_add_pipe #(.WIDTH(16), .STAGES(2), .APPROX_BITS(3)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .approx_en(approx_en0), .out_valid(out_valid0),
        .out_ready(out_ready0), .sum(sum0), .sum_approx(sum_approx0));
    approx_add_pipe #(.WIDTH(32), .STAGES(4), .APPROX_BITS(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .approx_en(approx_en2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .sum_approx(sum_approx2));
    approx_add_pipe #(.WIDTH(8), .STAGES(1), .APPROX_BITS(7)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .approx_en(approx_en3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sum(sum3), .sum_approx(sum_approx3));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [64:0] sum;
        logic        mode;
        bit          lat;
        longint      t;
    } exp_t;
    exp_t q0[$];
    exp_t q2[$];
    exp_t q3[$];

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int sel, input logic [63:0] aa, input logic [63:0] bb,
                        input logic m, input logic [64:0] e, input bit lat);
        exp_t it;
        bit   ok;
        logic rdy;
        ok = 1'b0;
        case (sel)
            0:       begin a0 = aa[15:0]; b0 = bb[15:0]; approx_en0 = m; in_valid0 = 1'b1; end
            2:       begin a2 = aa[31:0]; b2 = bb[31:0]; approx_en2 = m; in_valid2 = 1'b1; end
            default: begin a3 = aa[7:0];  b3 = bb[7:0];  approx_en3 = m; in_valid3 = 1'b1; end
        endcase
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? in_ready0 : (sel == 2) ? in_ready2 : in_ready3;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_within_budget", 65'(ok), 65'(1));
        @(posedge clk);
        it = '{sum: e, mode: m, lat: lat, t: longint'($time)};
        if (ok) begin
            case (sel)
                0:       q0.push_back(it);
                2:       q2.push_back(it);
                default: q3.push_back(it);
            endcase
        end
        #1;
        in_valid0 = 1'b0;
        in_valid2 = 1'b0;
        in_valid3 = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q2.size() == 0 && q3.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        check("drain_within_budget", 65'(empty), 65'(1));
        @(posedge clk);
        #1;
    endtask

    // dut0 monitor: ordering, values, latency, stall stability, in_ready.
    bit          m0_prev_stall = 1'b0;
    bit          m0_seen       = 1'b0;
    logic [16:0] m0_prev_sum;
    logic        m0_prev_mode;
    exp_t        m0_it;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            m0_prev_stall = 1'b0;
            m0_seen       = 1'b0;
        end else begin
            if (m0_prev_stall) begin
                check("stall_valid", 65'(out_valid0), 65'(1));
                check("stall_sum", 65'(sum0), 65'(m0_prev_sum));
                check("stall_mode", 65'(sum_approx0), 65'(m0_prev_mode));
            end
            // Two beats in a two-stage pipe means both slots are full.
            check("in_ready", 65'(in_ready0), 65'(q0.size() < 2 || out_ready0));
            if (out_valid0) begin
                check("out_has_expected", 65'(q0.size() != 0), 65'(1));
                if (q0.size() != 0) begin
                    if (!m0_seen && q0[0].lat)
                        check("latency", 65'($time - q0[0].t), 65'(15));
                    m0_seen = 1'b1;
                    if (out_ready0) begin
                        m0_it = q0.pop_front();
                        check("sum", 65'(sum0), m0_it.sum);
                        check("sum_approx", 65'(sum_approx0), 65'(m0_it.mode));
                        m0_seen = 1'b0;
                    end
                end
            end
            m0_prev_stall = out_valid0 && !out_ready0;
            m0_prev_sum   = sum0;
            m0_prev_mode  = sum_approx0;
        end
    end

    exp_t m2_it;
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid2 && out_ready2) begin
            check("dut2_has_expected", 65'(q2.size() != 0), 65'(1));
            if (q2.size() != 0) begin
                m2_it = q2.pop_front();
                check("dut2_sum", 65'(sum2), m2_it.sum);
                check("dut2_mode", 65'(sum_approx2), 65'(m2_it.mode));
            end
        end
    end

    exp_t m3_it;
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid3 && out_ready3) begin
            check("dut3_has_expected", 65'(q3.size() != 0), 65'(1));
            if (q3.size() != 0) begin
                m3_it = q3.pop_front();
                check("dut3_sum", 65'(sum3), m3_it.sum);
                check("dut3_mode", 65'(sum_approx3), 65'(m3_it.mode));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit          bp_on;
    logic [15:0] ra, rb;
    logic [31:0] ra2, rb2;
    logic        rm;

    initial begin
        rst = 1'b1;
        in_valid0 = 1'b0; a0 = '0; b0 = '0; approx_en0 = 1'b0; out_ready0 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; approx_en2 = 1'b0; out_ready2 = 1'b1;
        in_valid3 = 1'b0; a3 = '0; b3 = '0; approx_en3 = 1'b0; out_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", 65'(out_valid0), 65'(0));
        check("reset_sum", 65'(sum0), 65'(0));
        check("reset_sum_approx", 65'(sum_approx0), 65'(0));
        check("reset_in_ready", 65'(in_ready0), 65'(1));
        check("reset_out_valid_dut2", 65'(out_valid2), 65'(0));

        // Directed back-to-back beats, out_ready held high: latency 2 each.
        send(0, 64'h0007, 64'h0001, 1'b0, 65'h00008, 1'b1);
        send(0, 64'h0007, 64'h0001, 1'b1, 65'h00007, 1'b1);
        send(0, 64'hFFFF, 64'h0001, 1'b0, 65'h10000, 1'b1);
        send(0, 64'hFFFF, 64'h0001, 1'b1, 65'h0FFFF, 1'b1);
        send(0, 64'h0004, 64'h0004, 1'b1, 65'h0000C, 1'b1);
        send(0, 64'hFFFF, 64'hFFFF, 1'b0, 65'h1FFFE, 1'b1);
        send(0, 64'hFFFF, 64'hFFFF, 1'b1, 65'h1FFFF, 1'b1);
        send(0, 64'h00FF, 64'h0001, 1'b0, 65'h00100, 1'b1);
        send(0, 64'h00FF, 64'h0001, 1'b1, 65'h000FF, 1'b1);
        drain();

        // Backpressure: out_ready pattern 1,0,0 repeating.
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rm = 1'($urandom);
                    send(0, 64'(ra), 64'(rb), rm,
                         loa_sum(64'(ra), 64'(rb), rm ? 3 : 0, 16), 1'b0);
                end
                bp_on = 1'b0;
            end
            begin
                for (int k = 0; bp_on; k++) begin
                    out_ready0 = ((k % 3) == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready0 = 1'b1;
        drain();

        // Reset with two beats in flight.
        out_ready0 = 1'b0;
        send(0, 64'h1234, 64'h1111, 1'b0, 65'h02345, 1'b0);
        send(0, 64'h0F0F, 64'h0101, 1'b1, loa_sum(64'h0F0F, 64'h0101, 3, 16), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        check("midrst_out_valid", 65'(out_valid0), 65'(0));
        check("midrst_sum", 65'(sum0), 65'(0));
        check("midrst_sum_approx", 65'(sum_approx0), 65'(0));
        out_ready0 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send(0, 64'h0003, 64'h0005, 1'b1, 65'h00007, 1'b1);
        send(0, 64'h0003, 64'h0005, 1'b0, 65'h00008, 1'b1);
        drain();

        // WIDTH=32, STAGES=4, APPROX_BITS=0: both modes give a+b.
        send(2, 64'hFFFF_FFFF, 64'h1, 1'b1, 65'h1_0000_0000, 1'b0);
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    ra2 = $urandom;
                    rb2 = $urandom;
                    rm  = 1'($urandom);
                    send(2, 64'(ra2), 64'(rb2), rm, 65'(ra2) + 65'(rb2), 1'b0);
                end
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    out_ready2 = (($urandom % 4) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready2 = 1'b1;
        drain();

        // WIDTH=8, STAGES=1, APPROX_BITS=7.
        send(3, 64'hC0, 64'h40, 1'b1, 65'h140, 1'b0);
        send(3, 64'hC0, 64'h40, 1'b0, 65'h100, 1'b0);
        send(3, 64'h80, 64'h80, 1'b1, 65'h100, 1'b0);
        send(3, 64'h7F, 64'h01, 1'b1, 65'h07F, 1'b0);
        send(3, 64'h7F, 64'h01, 1'b0, 65'h080, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom % 256);
            rb = 16'($urandom % 256);
            send(3, 64'(ra), 64'(rb), 1'b1, loa_sum(64'(ra), 64'(rb), 7, 8), 1'b0);
        end
        drain();

        check("q0_empty", 65'(q0.size()), 65'(0));
        check("q2_empty", 65'(q2.size()), 65'(0));
        check("q3_empty", 65'(q3.size()), 65'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
